pool_window_feeder: RTL and testbench
=====================================

POOL_WINDOW_FEEDER -- requirements
Module: pool_window_feeder

Interface
REQ-001 SHALL have parameter IMG_W, default 28, meaning feature-map width in pixels; it must be even and at least 2, otherwise elaboration fails.
REQ-002 SHALL have parameter IMG_H, default 28, meaning feature-map height in pixels; it must be even and at least 2, otherwise elaboration fails.
REQ-003 SHALL have parameter DATA_W, default 16, meaning pixel width.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input pixel valid
- in_ready  out  1  feeder accepts pixel
- in_pixel  in  DATA_W  raster-order input pixel
- pool_start  out  1  window valid to pooling unit
- pool_win00 / pool_win01 / pool_win10 / pool_win11  out  DATA_W each  2x2 window, as top-left / top-right / bottom-left / bottom-right
- pool_finish  in  1  pooling result valid
- pool_pixel  in  DATA_W  pooling result
- out_valid  out  1  pooled pixel valid
- out_ready  in  1  downstream accepts
- out_pixel  out  DATA_W  pooled pixel
- out_last  out  1  last pooled pixel of frame

Function
REQ-006 SHALL accept a pixel only on a cycle where in_valid and in_ready are both 1, and SHALL track column (0..IMG_W-1) and row (0..IMG_H-1) counters.
REQ-007 SHALL write each even-row pixel into a line buffer at its column index.
REQ-008 SHALL, on odd rows, hold each even-column pixel in a left register.
REQ-009 SHALL, on accepting an odd-row, odd-column pixel, form the window as follows and move to ISSUE:
- pool_win00 = line[col-1]
- pool_win01 = line[col]
- pool_win10 = left register
- pool_win11 = current pixel
REQ-010 SHALL implement a three-state FSM with these transitions:
- ACCEPT: in_ready=1.
- ISSUE: pool_start=1 and window held stable. Stay in ISSUE until pool_finish=1. On pool_finish=1, capture pool_pixel into out_pixel and go to DRAIN.
- DRAIN: out_valid=1. Stay until out_ready=1, then go to ACCEPT.
REQ-011 SHALL hold in_ready at 0 in ISSUE and DRAIN; pixels arriving then are not consumed.
REQ-012 SHALL have latency as follows, with the window-completing pixel accepted at cycle t:
- pool_start=1 at t+1
- if pool_finish=1 at t+1, out_valid=1 at t+2
REQ-013 SHALL keep out_pixel and out_last stable while out_valid=1 and out_ready=0.
REQ-014 SHALL set out_last=1 with the window completed at row IMG_H-1, column IMG_W-1.
REQ-015 SHALL wrap the column counter at IMG_W-1 and the row counter at IMG_H-1 to 0, so the next pixel starts a new frame with no idle cycle.
REQ-016 SHALL emit exactly (IMG_W/2)*(IMG_H/2) pooled pixels per frame.
REQ-017 SHALL ignore pool_finish outside ISSUE.
REQ-018 SHALL pass pool_pixel through unchanged; it performs no arithmetic on the result.

Reset
REQ-019 SHALL, when rst=1, load the following, and SHALL discard any partial frame or pending result:
- FSM = ACCEPT
- counters = 0
- left register = 0
- pool_start = 0
- out_valid = 0
- out_last = 0
- out_pixel = 0
- pool_win* = 0
REQ-020 SHALL drive in_ready=1 on the first cycle after rst deasserts; line-buffer contents are don't-care after reset.

Configuration
REQ-021 SHALL, when macro POOL_FEEDER_STATUS_EN is defined, add the following outputs:
- frame_done (1 bit): pulses for one cycle on the out_last handshake.
- frame_cnt (16 bits): increments on the same handshake, wraps at 0xFFFF to 0, and resets to 0.
REQ-022 SHALL, without POOL_FEEDER_STATUS_EN, omit both ports and their logic.

Structure
REQ-023 SHALL take the FSM state enum and the DATA_W default from shared package pool_pkg.
REQ-024 SHALL place the IMG_W x DATA_W line buffer in sub-module pool_line_buf, which has one write port and two combinational read ports (col-1, col).

Verification
REQ-025 With a 4x4 frame, in_pixel=0..15 in raster order, and the bench model pool_pixel=(w00+w01+w10+w11)>>2 with same-cycle finish, out_pixel SHALL be 2, 4, 10, 12, with out_last only on 12.
REQ-026 With out_ready=0 for 5 cycles during the first result, out_pixel SHALL stay at 2, in_ready SHALL stay 0, and no input SHALL be consumed.
REQ-027 With pool_finish held 0 for 3 cycles, pool_start SHALL stay 1 with the window stable for 4 cycles, and one output SHALL follow.
REQ-028 With rst asserted after 6 pixels, a following full 4x4 frame SHALL produce exactly 4 outputs that match REQ-025.
REQ-029 With two back-to-back 4x4 frames, 8 outputs SHALL appear with out_last on the 4th and 8th, and with POOL_FEEDER_STATUS_EN defined frame_cnt SHALL end at 2.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 pooling window feeder.
//   POOL_DATA_W  : default pixel width
//   pool_state_t : feeder FSM states (ACCEPT -> ISSUE -> DRAIN)
package pool_pkg;

    localparam int POOL_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2
    } pool_state_t;

endpackage

// File: rtl/pool_line_buf.sv
// One-row line buffer holding the even-row pixels of the current row pair.
// Ports:
//   clk                      : clock
//   wr_en / wr_addr / wr_data : synchronous write port
//   rd_addr_a / rd_data_a    : combinational read port (left column of window)
//   rd_addr_b / rd_data_b    : combinational read port (right column of window)
// Contents are not reset; every location is rewritten before it is read.
module pool_line_buf
    import pool_pkg::*;
#(
    parameter int IMG_W  = 28,
    parameter int DATA_W = POOL_DATA_W,
    parameter int AW     = 5
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [AW-1:0]     rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b
);

    logic [DATA_W-1:0] mem [IMG_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = mem[rd_addr_a];
    assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/pool_window_feeder.sv
// Collects a raster-order feature map into 2x2 windows, hands each window to
// an external pooling unit, and forwards the pooled result downstream.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready/in_pixel : raster pixel input
//   pool_start, pool_win00..11 : window to pooling unit (TL, TR, BL, BR)
//   pool_finish, pool_pixel   : pooling result
//   out_valid/out_ready/out_pixel/out_last : pooled pixel output
// Optional (macro POOL_FEEDER_STATUS_EN):
//   frame_done : one-cycle pulse on the out_last handshake
//   frame_cnt  : 16-bit count of completed frames
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; a producer holds its data stable while valid=1 and ready=0.
module pool_window_feeder
    import pool_pkg::*;
#(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int DATA_W = POOL_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pixel,
    output logic              pool_start,
    output logic [DATA_W-1:0] pool_win00,
    output logic [DATA_W-1:0] pool_win01,
    output logic [DATA_W-1:0] pool_win10,
    output logic [DATA_W-1:0] pool_win11,
    input  logic              pool_finish,
    input  logic [DATA_W-1:0] pool_pixel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pixel,
    output logic              out_last
`ifdef POOL_FEEDER_STATUS_EN
    ,
    output logic              frame_done,
    output logic [15:0]       frame_cnt
`endif
);

    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    if ((IMG_W < 2) || ((IMG_W % 2) != 0)) begin : g_bad_img_w
        $error("IMG_W must be even and at least 2");
    end
    if ((IMG_H < 2) || ((IMG_H % 2) != 0)) begin : g_bad_img_h
        $error("IMG_H must be even and at least 2");
    end

    pool_state_t state_q, state_d;

    logic [AW-1:0]     col_q;
    logic [RW-1:0]     row_q;
    logic [DATA_W-1:0] left_q;
    logic              last_win_q;
    logic              accept;
    logic              win_done;
    logic              col_end;
    logic              row_end;
    logic [DATA_W-1:0] line_a;
    logic [DATA_W-1:0] line_b;

    assign accept   = in_valid && in_ready;
    assign col_end  = (col_q == AW'(IMG_W - 1));
    assign row_end  = (row_q == RW'(IMG_H - 1));
    // An odd-row, odd-column pixel is the bottom-right corner of a window.
    assign win_done = accept && row_q[0] && col_q[0];

    // Even rows fill the line buffer; odd rows read it back as the window top.
    pool_line_buf #(
        .IMG_W  (IMG_W),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_line_buf (
        .clk       (clk),
        .wr_en     (accept && !row_q[0]),
        .wr_addr   (col_q),
        .wr_data   (in_pixel),
        .rd_addr_a (col_q - AW'(1)),
        .rd_data_a (line_a),
        .rd_addr_b (col_q),
        .rd_data_b (line_b)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACCEPT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and state-decoded outputs
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        pool_start = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            ST_ACCEPT: begin
                in_ready = 1'b1;
                if (win_done) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                pool_start = 1'b1;
                if (pool_finish) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_ACCEPT;
                end
            end
            default: begin
                state_d = ST_ACCEPT;
            end
        endcase
    end

    // Datapath: counters, left register, window and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            left_q     <= '0;
            last_win_q <= 1'b0;
            pool_win00 <= '0;
            pool_win01 <= '0;
            pool_win10 <= '0;
            pool_win11 <= '0;
            out_pixel  <= '0;
            out_last   <= 1'b0;
        end else begin
            if (accept) begin
                if (col_end) begin
                    col_q <= '0;
                    row_q <= row_end ? '0 : row_q + RW'(1);
                end else begin
                    col_q <= col_q + AW'(1);
                end
                if (row_q[0] && !col_q[0]) begin
                    left_q <= in_pixel;
                end
            end
            if (win_done) begin
                pool_win00 <= line_a;
                pool_win01 <= line_b;
                pool_win10 <= left_q;
                pool_win11 <= in_pixel;
                last_win_q <= row_end && col_end;
            end
            if ((state_q == ST_ISSUE) && pool_finish) begin
                out_pixel <= pool_pixel;
                out_last  <= last_win_q;
            end else if ((state_q == ST_DRAIN) && out_ready) begin
                out_last <= 1'b0;
            end
        end
    end

`ifdef POOL_FEEDER_STATUS_EN
    assign frame_done = out_valid && out_ready && out_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (frame_done) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pool_window_feeder.sv
// Directed bench for pool_window_feeder on a 4x4 frame with an averaging
// pooling model that answers in the same cycle unless finish_en is held low.
module tb_pool_window_feeder;

    localparam int W  = 16;
    localparam int EW = W + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_pixel;
    logic         pool_start;
    logic [W-1:0] pool_win00, pool_win01, pool_win10, pool_win11;
    logic         pool_finish;
    logic [W-1:0] pool_pixel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_pixel;
    logic         out_last;
`ifdef POOL_FEEDER_STATUS_EN
    logic         frame_done;
    logic [15:0]  frame_cnt;
`endif

    logic         finish_en;
    logic [17:0]  pool_sum;
    logic [EW-1:0] exp_q[$];
    int           n_cmp  = 0;
    int           n_fail = 0;
    int           n_frame_done = 0;

    always #5 clk = ~clk;

    pool_window_feeder #(
        .IMG_W  (4),
        .IMG_H  (4),
        .DATA_W (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pixel    (in_pixel),
        .pool_start  (pool_start),
        .pool_win00  (pool_win00),
        .pool_win01  (pool_win01),
        .pool_win10  (pool_win10),
        .pool_win11  (pool_win11),
        .pool_finish (pool_finish),
        .pool_pixel  (pool_pixel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pixel   (out_pixel),
        .out_last    (out_last)
`ifdef POOL_FEEDER_STATUS_EN
        ,
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt)
`endif
    );

    // Pooling unit model: average of the four window pixels.
    assign pool_sum    = 18'(pool_win00) + 18'(pool_win01) + 18'(pool_win10) + 18'(pool_win11);
    assign pool_pixel  = pool_sum[17:2];
    assign pool_finish = finish_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge after the pixel was taken.
    task automatic send_pixel(input logic [W-1:0] p);
        int n = 0;
        in_valid = 1'b1;
        in_pixel = p;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("send_timeout", 32'(n), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_range(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            send_pixel(W'(i));
        end
    endtask

    task automatic push_frame();
        exp_q.push_back({1'b0, 16'd2});
        exp_q.push_back({1'b0, 16'd4});
        exp_q.push_back({1'b0, 16'd10});
        exp_q.push_back({1'b1, 16'd12});
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor / scoreboard: compares every output handshake against exp_q.
    always begin
        @(negedge clk);
        #1;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {15'd0, out_last, out_pixel}, 32'hFFFF_FFFF);
            end else begin
                chk("out_pixel_last", {15'd0, out_last, out_pixel}, 32'(exp_q.pop_front()));
            end
        end
`ifdef POOL_FEEDER_STATUS_EN
        if (!rst && frame_done) begin
            n_frame_done++;
        end
`endif
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_pixel  = '0;
        out_ready = 1'b1;
        finish_en = 1'b1;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_pool_start", 32'(pool_start), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_pixel", 32'(out_pixel), 32'd0);
        chk("rst_win", {pool_win00 | pool_win01, pool_win10 | pool_win11}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Basic 4x4 frame
        push_frame();
        send_range(0, 15);
        wait_drain();

        // Downstream stall on first result
        out_ready = 1'b0;
        push_frame();
        send_range(0, 5);
        in_valid = 1'b1;
        in_pixel = 16'd6;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_out_pixel", 32'(out_pixel), 32'd2);
            chk("stall_out_last", 32'(out_last), 32'd0);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        send_range(6, 15);
        wait_drain();

        // Pooling unit slow to finish
        finish_en = 1'b0;
        push_frame();
        send_range(0, 5);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) finish_en = 1'b1;
            chk("hold_pool_start", 32'(pool_start), 32'd1);
            chk("hold_win", {pool_win00[7:0], pool_win01[7:0], pool_win10[7:0], pool_win11[7:0]},
                32'h00_01_04_05);
            chk("hold_out_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        send_range(6, 15);
        wait_drain();

        // Reset in the middle of a frame with a result pending
        send_range(0, 5);
        do_reset();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        push_frame();
        send_range(0, 15);
        wait_drain();

        // Two back-to-back frames from a fresh reset
        do_reset();
        n_frame_done = 0;
        push_frame();
        push_frame();
        send_range(0, 15);
        send_range(0, 15);
        wait_drain();
`ifdef POOL_FEEDER_STATUS_EN
        chk("frame_cnt", 32'(frame_cnt), 32'd2);
        chk("frame_done_pulses", 32'(n_frame_done), 32'd2);
`endif

        repeat (4) @(negedge clk);
        chk("no_stray_out", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
